// File: rtl/rv_program_loader.sv
// UART boot loader: parses SYNC/LEN/payload/CSUM frames and writes the payload
// into byte-addressed instruction memory, holding the CPU in reset until a good image lands.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   rx_data, rx_valid   : byte stream from the UART receiver (one-cycle strobes)
//   mem_we/addr/data    : instruction-memory byte write port (registered)
//   cpu_rst_n           : CPU reset, low while an image is loading or after a failed load
//   load_busy           : frame in progress
//   load_done, load_err : sticky status of the last frame
//   err_code            : 01 length too big, 10 bad checksum, 11 inter-byte timeout
module rv_program_loader #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned MEM_BYTES      = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam int unsigned IW = ADDR_W + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] LEN_MAX = 17'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [15:0]       len_q;
  logic [IW-1:0]     idx_q;
  logic [7:0]        csum_q;
  logic [TW-1:0]     tmo_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_data_q;
  logic              cpu_rst_n_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        code_q;

  // Full 16-bit length as it stands when LEN_HI arrives, with a spare
  // top bit so the range check against MEM_BYTES cannot wrap.
  logic [16:0] len_in;
  assign len_in = {1'b0, rx_data, len_q[7:0]};

  // Payload index of the byte currently arriving is the last one.
  logic last_byte;
  assign last_byte = (16'(idx_q) + 16'd1) == len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      mem_we_q <= 1'b0;
      if (rx_valid) begin
        tmo_q <= '0;
      end else if (busy_q) begin
        tmo_q <= tmo_q + 1'b1;
      end

      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q     <= S_LEN_LO;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'b00;
            csum_q      <= '0;
            idx_q       <= '0;
            cpu_rst_n_q <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            len_q[7:0] <= rx_data;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            len_q[15:8] <= rx_data;
            if (len_in > LEN_MAX) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              code_q  <= 2'b01;
            end else if (len_in == '0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= idx_q[ADDR_W-1:0];
            mem_data_q <= rx_data;
            csum_q     <= csum_q + rx_data;
            idx_q      <= idx_q + 1'b1;
            if (last_byte) begin
              state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (rx_valid) begin
            busy_q <= 1'b0;
            if (rx_data == csum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              code_q  <= 2'b10;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // A byte in the same cycle always wins over the timeout.
      if (busy_q && !rx_valid && tmo_q == TMO_LAST) begin
        state_q <= S_ERR;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        code_q  <= 2'b11;
        tmo_q   <= '0;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_rv_program_loader.sv
// Scoreboard bench for rv_program_loader: a frame-level model predicts
// memory writes (queued) and final status; a monitor pops on every mem_we.
module tb_rv_program_loader;

  localparam int TMO = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_rst_n;
  logic       load_busy;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;

  rv_program_loader #(
    .ADDR_W(10),
    .MEM_BYTES(1024),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .cpu_rst_n(cpu_rst_n),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fr[$];
  int         checks = 0;
  int         errors = 0;

  logic       e_done;
  logic       e_err;
  logic [1:0] e_code;
  logic       e_cpu;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h/%0h expected=none",
                 mem_addr, mem_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.a));
        chk("wr_data", 32'(mem_data), 32'(w.d));
      end
    end
  end

  // Frame-level reference: derive writes and outcome from the byte list.
  task automatic model(input bit complete);
    int  len;
    int  sum;
    wr_t w;
    len = {24'd0, fr[2], fr[1]};
    sum = 0;
    if (len > 1024) begin
      e_done = 0; e_err = 1; e_code = 2'b01; e_cpu = 0;
      return;
    end
    for (int i = 0; i < len && 3 + i < fr.size(); i++) begin
      w.a = 10'(i);
      w.d = fr[3+i];
      exp_q.push_back(w);
      sum = (sum + fr[3+i]) % 256;
    end
    if (!complete) begin
      e_done = 0; e_err = 1; e_code = 2'b11; e_cpu = 0;
    end else if (fr[3+len] == 8'(sum)) begin
      e_done = 1; e_err = 0; e_code = 2'b00; e_cpu = 1;
    end else begin
      e_done = 0; e_err = 1; e_code = 2'b10; e_cpu = 0;
    end
  endtask

  task automatic drive(input int maxgap);
    for (int i = 0; i < fr.size(); i++) begin
      rx_data  = fr[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      if (i == 0 && fr[0] == 8'hA5) begin
        chk("cpu_rst_fall", 32'(cpu_rst_n), 0);
        chk("busy_rise", 32'(load_busy), 1);
      end
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic status(input string tag, input logic busy);
    chk({tag, "_done"}, 32'(load_done), 32'(e_done));
    chk({tag, "_err"}, 32'(load_err), 32'(e_err));
    chk({tag, "_code"}, 32'(err_code), 32'(e_code));
    chk({tag, "_cpu"}, 32'(cpu_rst_n), 32'(e_cpu));
    chk({tag, "_busy"}, 32'(load_busy), 32'(busy));
  endtask

  task automatic run(input string tag, input int maxgap);
    model(1'b1);
    drive(maxgap);
    status(tag, 1'b0);
    @(negedge clk);
    chk({tag, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_data"}, 32'(mem_data), 0);
    chk({tag, "_cpu"}, 32'(cpu_rst_n), 1);
    chk({tag, "_busy"}, 32'(load_busy), 0);
    chk({tag, "_done"}, 32'(load_done), 0);
    chk({tag, "_err"}, 32'(load_err), 0);
    chk({tag, "_code"}, 32'(err_code), 0);
  endtask

  initial begin
    int len;
    int sum;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    fr = '{8'h55};
    drive(0);
    reset_vals("ign55");

    fr = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run("good4", 2);

    fr = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    run("badcs", 1);

    fr = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run("recover", 0);

    fr = '{8'hA5, 8'h01, 8'h04};
    run("len1025", 1);

    fr = '{8'hA5, 8'h00, 8'h04};
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      fr.push_back(8'($urandom));
      sum += fr[3+i];
    end
    fr.push_back(8'(sum));
    run("len1024", 0);

    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run("len0", 1);

    fr = '{8'hA5, 8'h02, 8'h00, 8'hAA};
    model(1'b0);
    drive(0);
    repeat (TMO + 4) @(negedge clk);
    status("tmo", 1'b0);
    chk("tmo_pending", 32'(exp_q.size()), 0);

    fr = '{8'hA5, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33};
    model(1'b0);
    drive(0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_vals("midrst");
    fr = '{8'h44, 8'h55, 8'h66};
    drive(0);
    repeat (2) @(negedge clk);
    reset_vals("post_rst");
    chk("midrst_pending", 32'(exp_q.size()), 0);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(1025, 65535);
        fr = '{8'hA5, 8'(len), 8'(len >> 8)};
      end else begin
        len = $urandom_range(0, 40);
        fr = '{8'hA5, 8'(len), 8'(len >> 8)};
        sum = 0;
        for (int i = 0; i < len; i++) begin
          fr.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom));
          sum += fr[3+i];
        end
        if ($urandom_range(0, 3) == 0) begin
          sum ^= $urandom_range(1, 255);
        end
        fr.push_back(8'(sum));
      end
      run("rand", 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
